multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle ARM datapath: one shared ALU, one unified instruction/data memory, an instruction register. A Moore main FSM sequences each instruction through 3–5 cycles and drives every datapath select and write strobe. An internal NZCV flags register plus a registered condition result gate all architectural writes. Sits beside the multicycle datapath, replacing the single-cycle decode/condlogic pair.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- Instr  in  32  IR contents; uses [31:28] cond, [27:26] op, [25:20] funct, [15:12] Rd, [7:4]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR enable
- ResultSrc  out  2  00 ALUOut, 01 Data reg, 10 ALU result direct
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL
- ALUSrcA  out  1  0 = RD1 reg, 1 = PC
- ALUSrcB  out  2  00 WD reg, 01 ExtImm, 10 constant 4
- ImmSrc  out  2  equals Instr[27:26]
- RegWrite  out  1  register file write strobe
- RegSrc  out  2  [0]=1 for branch (read R15), [1]=1 for STR (read Rd as RA2)

## Operation
- States (4-bit): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 → DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10; capture CondExR = condition(Instr[31:28], flags). Next: op=01 → MEMADR; op=00 & funct[5] → EXECUTEI; op=00 & !funct[5] → EXECUTER; op=10 → BRANCH; op=11 → UNKNOWN.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD if funct[3] (U) else SUB; funct[0] (L) ? MEMREAD : MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00 → MEMWB. MEMWB: ResultSrc=01, RegWrite=CondExR → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=CondExR → FETCH.
- EXECUTER/EXECUTEI: ALUSrcA=0, ALUSrcB=00/01, ALUControl from cmd funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no writeback); others ADD, no writeback, no flags. → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondExR & writeback-enabled → FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondExR → FETCH.
- UNKNOWN: all strobes 0 → FETCH.
- PC-targeting write (PCS): in MEMWB/ALUWB with Rd=15, PCWrite=CondExR and RegWrite=0.
- Flags: in EXECUTER/EXECUTEI, if CondExR & S (funct[0]) — or cmd CMP — update NZ at clock edge; also CV for ADD/SUB/CMP only.
- Conditions: standard ARM EQ..LE, 1110 AL=1, 1111 = 0.
- Unused outputs in a state drive 0; ALUControl defaults ADD.

## Timing
- Outputs are functions of registered state, CondExR and Instr; no combinational path from ALUFlags to any output.
- Cycle counts: B 3, data-processing 4, STR 4, LDR 5, UNKNOWN 3.
- CondExR is written only on the DECODE→next edge; flags write in EXECUTE does not alter CondExR for the same instruction.
- Reset asserted: state=FETCH, flags=0000, CondExR=0; PCWrite, IRWrite, RegWrite, MemWrite forced 0 while reset low. First edge after release performs the FETCH actions.
- Reset mid-instruction: immediately abandons state; no pending strobe survives.

## Configuration
- MULTICYCLE_CTRL_MUL_EN defined: op=00, funct[5]=0, cmd=0000, Instr[7:4]=1001 decodes as MUL (ALUControl=100), Rd from Instr[19:16] handled by datapath; flags NZ only with S.
- Undefined: that encoding decodes as AND; ALUControl never 100.

## Test plan
- Reset low mid-MEMREAD, release → all strobes 0 during reset; next cycle FETCH with PCWrite=1, IRWrite=1.
- ADD R1,R2,#5 (0xE2821005) → 4 cycles FETCH,DECODE,EXECUTEI,ALUWB; RegWrite=1 only in ALUWB; ALUSrcB=01 in EXECUTEI.
- CMP R0,R0 (SUB flags Z=1) then BNE → BRANCH state with PCWrite=0; BEQ → PCWrite=1.
- LDR R3,[R4,#8] → 5 cycles; AdrSrc=1 in MEMREAD; ResultSrc=01, RegWrite=1 in MEMWB; STR equivalent → MemWrite=1 in MEMWRITE, RegSrc[1]=1.
- ADDNE with Z=1 and S=1 → RegWrite=0, flags unchanged; MOV-like PC write (Rd=15, AL) → PCWrite=1, RegWrite=0 in ALUWB.
- Op=11 instruction → UNKNOWN then FETCH, zero writes; with MUL_EN, 0xE0010392 → ALUControl=100 in EXECUTER.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main-FSM control unit for the multicycle ARM datapath, with NZCV flags and registered condition result.
// Optional MUL decode is enabled by defining MULTICYCLE_CTRL_MUL_EN.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ALUControl,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic        RegWrite,
    output logic [1:0]  RegSrc
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;

    state_t     state_reg, state_next;
    logic [3:0] flags_reg;
    logic       condex_reg;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] dst_rd;
    logic       is_mul, is_cmp, pcs;
    logic [2:0] dp_alu;
    logic       dp_wb, dp_nz, dp_cv, flag_wr;
    logic       unused_bits;

    logic       pc_write, mem_write, ir_write, reg_write;

    assign op     = Instr[27:26];
    assign funct  = Instr[25:20];
    assign cmd    = funct[4:1];
    assign unused_bits = ^{Instr[19:16], Instr[11:0]};

`ifdef MULTICYCLE_CTRL_MUL_EN
    assign is_mul = (op == 2'b00) && !funct[5] && (cmd == 4'b0000) && (Instr[7:4] == 4'b1001);
    assign dst_rd = is_mul ? Instr[19:16] : Instr[15:12];
`else
    assign is_mul = 1'b0;
    assign dst_rd = Instr[15:12];
`endif

    assign is_cmp = !is_mul && (cmd == 4'b1010);
    assign pcs    = (dst_rd == 4'hF);

    // Data-processing decode: ALU op, whether it writes a register, which flags it may set.
    always_comb begin
        dp_alu = ALU_ADD;
        dp_wb  = 1'b0;
        dp_nz  = 1'b0;
        dp_cv  = 1'b0;
        if (is_mul) begin
            dp_alu = ALU_MUL;
            dp_wb  = 1'b1;
            dp_nz  = 1'b1;
        end else begin
            case (cmd)
                4'b0100: begin dp_alu = ALU_ADD; dp_wb = 1'b1; dp_nz = 1'b1; dp_cv = 1'b1; end
                4'b0010: begin dp_alu = ALU_SUB; dp_wb = 1'b1; dp_nz = 1'b1; dp_cv = 1'b1; end
                4'b0000: begin dp_alu = ALU_AND; dp_wb = 1'b1; dp_nz = 1'b1; end
                4'b1100: begin dp_alu = ALU_ORR; dp_wb = 1'b1; dp_nz = 1'b1; end
                4'b1010: begin dp_alu = ALU_SUB; dp_nz = 1'b1; dp_cv = 1'b1; end
                default: ;
            endcase
        end
    end

    assign flag_wr = condex_reg && (funct[0] || is_cmp) && dp_nz;

    // Pairs of conditions share a base test; the low cond bit inverts it.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & ~z;
            3'd5:    base = n ~^ v;
            3'd6:    base = ~z & (n ~^ v);
            default: base = 1'b1;
        endcase
        return (c == 4'b1111) ? 1'b0 : (base ^ c[0]);
    endfunction

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b01:   state_next = S_MEMADR;
                    2'b00:   state_next = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_FETCH;
            flags_reg  <= 4'b0000;
            condex_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                condex_reg <= cond_holds(Instr[31:28], flags_reg);
            if ((state_reg == S_EXECUTER || state_reg == S_EXECUTEI) && flag_wr) begin
                flags_reg[3:2] <= ALUFlags[3:2];
                if (dp_cv)
                    flags_reg[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        AdrSrc     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        reg_write  = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_write  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_write  = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                if (pcs) pc_write = condex_reg;
                else     reg_write = condex_reg;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = condex_reg;
            end
            S_EXECUTER: ALUControl = dp_alu;
            S_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp_alu;
            end
            S_ALUWB: begin
                if (pcs) pc_write = condex_reg;
                else     reg_write = condex_reg & dp_wb;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_write  = condex_reg;
            end
            default: ;
        endcase
    end

    // Architectural strobes are held off for as long as reset is low.
    assign PCWrite  = pc_write  & reset;
    assign MemWrite = mem_write & reset;
    assign IRWrite  = ir_write  & reset;
    assign RegWrite = reg_write & reset;

    assign ImmSrc = op;
    assign RegSrc = {(op == 2'b01) && !funct[0], (op == 2'b10)};

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: a per-instruction cycle-table model plus directed literal checks.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [2:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] imm;
        logic       regw;
        logic [1:0] regsrc;
    } ov_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;

    ov_t  dut_o, exp_o;
    ov_t  obs [0:7];
    int   cyc_k;
    logic chk_en;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [3:0] flags_m;
    logic       cex_m;
    logic       force_en;
    logic [3:0] force_val;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .RegSrc(RegSrc)
    );

    always #5 clk = ~clk;

    assign dut_o = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                    ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc};

    // ---------------- reference model ----------------
    function automatic logic m_is_mul(input logic [31:0] ins);
`ifdef MULTICYCLE_CTRL_MUL_EN
        return ins[27:25] == 3'b000 && ins[24:21] == 4'b0000 && ins[7:4] == 4'b1001;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] m_rd(input logic [31:0] ins);
        return m_is_mul(ins) ? ins[19:16] : ins[15:12];
    endfunction

    function automatic logic [2:0] m_alu(input logic [31:0] ins);
        if (m_is_mul(ins)) return 3'b100;
        case (ins[24:21])
            4'b0010, 4'b1010: return 3'b001;
            4'b0000:          return 3'b010;
            4'b1100:          return 3'b011;
            default:          return 3'b000;
        endcase
    endfunction

    function automatic logic m_writes(input logic [31:0] ins);
        return m_is_mul(ins) || ins[24:21] inside {4'b0100, 4'b0010, 4'b0000, 4'b1100};
    endfunction

    function automatic logic m_sets_nz(input logic [31:0] ins);
        return m_writes(ins) || ins[24:21] == 4'b1010;
    endfunction

    function automatic logic m_sets_cv(input logic [31:0] ins);
        return !m_is_mul(ins) && ins[24:21] inside {4'b0100, 4'b0010, 4'b1010};
    endfunction

    function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int m_cycles(input logic [31:0] ins);
        case (ins[27:26])
            2'b01:   return ins[20] ? 5 : 4;
            2'b00:   return 4;
            default: return 3;
        endcase
    endfunction

    // Expected outputs for cycle k of an instruction (k=0 fetch, 1 decode, then class-specific).
    function automatic ov_t m_out(input int k, input logic [31:0] ins, input logic cex, input logic in_rst);
        ov_t o;
        logic [1:0] op;
        op = ins[27:26];
        o = '0;
        o.imm    = op;
        o.regsrc = {op == 2'b01 && !ins[20], op == 2'b10};
        if (k <= 1) begin
            o.srca = 1'b1; o.srcb = 2'b10; o.res = 2'b10;
            if (k == 0) begin o.pcw = 1'b1; o.irw = 1'b1; end
        end else if (op == 2'b01) begin
            if (k == 2) begin
                o.srcb = 2'b01;
                o.alu  = ins[23] ? 3'b000 : 3'b001;
            end else if (k == 3) begin
                o.adr  = 1'b1;
                o.memw = !ins[20] && cex;
            end else begin
                o.res = 2'b01;
                if (m_rd(ins) == 4'hF) o.pcw = cex; else o.regw = cex;
            end
        end else if (op == 2'b00) begin
            if (k == 2) begin
                o.srcb = ins[25] ? 2'b01 : 2'b00;
                o.alu  = m_alu(ins);
            end else begin
                if (m_rd(ins) == 4'hF) o.pcw = cex; else o.regw = cex && m_writes(ins);
            end
        end else if (op == 2'b10) begin
            o.srcb = 2'b01; o.res = 2'b10; o.pcw = cex;
        end
        if (in_rst) begin o.pcw = 0; o.irw = 0; o.regw = 0; o.memw = 0; end
        return o;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [16:0] a, e;
            a = dut_o;
            e = exp_o;
            obs[cyc_k] = dut_o;
            n_cmp++;
            if (dut_o !== exp_o) begin
                n_bad++;
                $display("FAIL cycle k=%0d instr=%h: outputs got %h want %h", cyc_k, instr, a, e);
            end
        end
    end

    task automatic lit(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Runs one instruction; abort_k >= 0 asserts reset partway through that cycle.
    task automatic run_instr(input logic [31:0] ins, input int abort_k);
        int n;
        n = m_cycles(ins);
        for (int k = 0; k < n; k++) begin
            if (k == 1) instr = ins;
            alu_flags = force_en ? force_val : 4'($urandom);
            cyc_k = k;
            exp_o = m_out(k, instr, cex_m, 1'b0);
            chk_en = 1'b1;
            if (k == abort_k) begin
                @(negedge clk);
                #1;
                reset = 1'b0;
                cex_m = 1'b0;
                flags_m = 4'b0000;
                exp_o = m_out(0, instr, 1'b0, 1'b1);
                cyc_k = 7;
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                reset = 1'b1;
                return;
            end
            @(posedge clk);
            if (k == 1) cex_m = m_cond(ins[31:28], flags_m);
            if (k == 2 && ins[27:26] == 2'b00 && cex_m &&
                (ins[20] || ins[24:21] == 4'b1010) && m_sets_nz(ins)) begin
                flags_m[3:2] = alu_flags[3:2];
                if (m_sets_cv(ins)) flags_m[1:0] = alu_flags[1:0];
            end
            #1;
        end
    endtask

    initial begin
        logic [31:0] r;
        int          ab;
        reset = 1'b0; instr = 32'h0; alu_flags = 4'h0;
        flags_m = 4'h0; cex_m = 1'b0; force_en = 1'b0; force_val = 4'h0;
        cyc_k = 7;
        exp_o = m_out(0, instr, 1'b0, 1'b1);
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        lit("rst_pcwrite", {3'b0, obs[7].pcw}, 4'h0);
        lit("rst_irwrite", {3'b0, obs[7].irw}, 4'h0);
        reset = 1'b1;

        run_instr(32'hE2821005, -1);                  // ADD R1,R2,#5
        lit("first_fetch_pcw_irw", {2'b0, obs[0].pcw, obs[0].irw}, 4'b0011);
        lit("addi_srcb", {2'b0, obs[2].srcb}, 4'b0001);
        lit("addi_regw_exec", {3'b0, obs[2].regw}, 4'h0);
        lit("addi_regw_wb", {3'b0, obs[3].regw}, 4'h1);

        force_en = 1'b1; force_val = 4'b0110;
        run_instr(32'hE1500000, -1);                  // CMP R0,R0 -> Z=1
        lit("cmp_alu", {1'b0, obs[2].alu}, 4'b0001);
        lit("cmp_regw", {3'b0, obs[3].regw}, 4'h0);
        run_instr(32'h1A000000, -1);                  // BNE
        lit("bne_pcw", {3'b0, obs[2].pcw}, 4'h0);
        run_instr(32'h0A000000, -1);                  // BEQ
        lit("beq_pcw", {3'b0, obs[2].pcw}, 4'h1);

        run_instr(32'hE5943008, -1);                  // LDR R3,[R4,#8]
        lit("ldr_adrsrc", {3'b0, obs[3].adr}, 4'h1);
        lit("ldr_wb_res_regw", {1'b0, obs[4].res, obs[4].regw}, 4'b0011);
        run_instr(32'hE5843008, -1);                  // STR R3,[R4,#8]
        lit("str_memw", {3'b0, obs[3].memw}, 4'h1);
        lit("str_regsrc", {2'b0, obs[3].regsrc}, 4'b0010);

        force_val = 4'b0000;
        run_instr(32'h12921005, -1);                  // ADDNES with Z=1
        lit("addne_regw", {3'b0, obs[3].regw}, 4'h0);
        run_instr(32'h0A000000, -1);                  // BEQ: flags must be untouched
        lit("beq_after_addne", {3'b0, obs[2].pcw}, 4'h1);
        force_en = 1'b0;

        run_instr(32'hE28FF000, -1);                  // ADD PC,PC,#0
        lit("pcs_pcw_regw", {2'b0, obs[3].pcw, obs[3].regw}, 4'b0010);
        run_instr(32'hEC000000, -1);                  // op=11
        lit("unknown_strobes", {obs[2].pcw, obs[2].regw, obs[2].memw, obs[2].irw}, 4'h0);

        run_instr(32'hE5943008, 3);                   // LDR, reset during MEMREAD
        lit("midreset_strobes", {obs[7].pcw, obs[7].regw, obs[7].memw, obs[7].irw}, 4'h0);
        run_instr(32'hE2821005, -1);
        lit("post_reset_fetch", {2'b0, obs[0].pcw, obs[0].irw}, 4'b0011);

        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if ($urandom_range(0, 2) == 0) r[31:28] = 4'hE;
            if (r[27:26] == 2'b00 && r[15:12] == 4'hF && !m_writes(r)) r[15:12] = 4'h0;
            ab = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, m_cycles(r) - 1)) : -1;
            run_instr(r, ab);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
